// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and flag bit indices for the accumulator core
package cpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LDA  = 4'h2;
   localparam logic [3:0] OP_STA  = 4'h3;
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_ADD  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_JC   = 4'hB;
   localparam logic [3:0] OP_LDB  = 4'hC;
   localparam logic [3:0] OP_SWP  = 4'hD;
   localparam logic [3:0] OP_OUT  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_EXEC      = 2'd0,
      ST_STALL_OUT = 2'd1,
      ST_HALTED    = 2'd2
   } state_t;

   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU; flag-neutral opcodes pass R0 and carry through
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              c_in,
   output logic [DATA_W-1:0] result,
   output logic              c_out,
   output logic              z
);

   always_comb begin
      result = a;
      c_out  = c_in;
      case (op)
         OP_ADD: {c_out, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            c_out  = (b > a);
         end
         OP_AND: result = a & b;
         OP_XOR: result = a ^ b;
         default: ;
      endcase
   end

   assign z = (result == '0);

endmodule

// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parametrised accumulator CPU with internal RAM, flags, branches,
// a handshaked OUT port and run/step/halt control
module cpu_core_param
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int ADDR_W  = 4,
   parameter int INSTR_W = 4 + ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               halted,
   input  logic [ADDR_W-1:0]  dbg_ram_addr,
   output logic [DATA_W-1:0]  dbg_ram_data,
   output logic [ADDR_W-1:0]  pc_debug,
   output logic [INSTR_W-1:0] instr_debug,
   output logic [DATA_W-1:0]  r0_debug,
   output logic [DATA_W-1:0]  r1_debug,
   output logic [1:0]         flags_debug
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_t              r_state, w_state_next;
   logic [ADDR_W-1:0]   r_pc, w_pc_next, w_pc_inc, w_operand;
   logic [3:0]          w_opcode;
   logic [DATA_W-1:0]   r_r0, r_r1, r_out_data, w_imm, w_alu_result;
   logic                r_c, r_z, r_out_valid, w_alu_c, w_alu_z;
   logic                w_exec, w_accept, w_out_load, w_out_stall, w_flag_op;
   logic [DATA_W-1:0]   r_ram [DEPTH];

   assign w_opcode  = imem_data[INSTR_W-1 -: 4];
   assign w_operand = imem_data[ADDR_W-1:0];
   assign w_pc_inc  = r_pc + ADDR_W'(1);

   generate
      if (ADDR_W >= DATA_W) begin : g_imm_trunc
         assign w_imm = w_operand[DATA_W-1:0];
      end else begin : g_imm_zext
         assign w_imm = {{(DATA_W-ADDR_W){1'b0}}, w_operand};
      end
   endgenerate

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (w_opcode),
      .a      (r_r0),
      .b      (r_r1),
      .c_in   (r_c),
      .result (w_alu_result),
      .c_out  (w_alu_c),
      .z      (w_alu_z)
   );

   assign w_exec    = (r_state == ST_EXEC) && (run || step);
   assign w_accept  = r_out_valid && out_ready;
   // An OUT may reload the port in the same cycle the old value is taken, so no bubble.
   assign w_out_load  = w_exec && (w_opcode == OP_OUT) && (!r_out_valid || w_accept);
   assign w_out_stall = w_exec && (w_opcode == OP_OUT) && !w_out_load;
   assign w_flag_op   = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                        (w_opcode == OP_AND) || (w_opcode == OP_XOR);

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      case (r_state)
         ST_EXEC: begin
            if (w_exec) begin
               w_pc_next = w_pc_inc;
               case (w_opcode)
                  OP_JMP: w_pc_next = w_operand;
                  OP_JZ:  if (r_z) w_pc_next = w_operand;
                  OP_JC:  if (r_c) w_pc_next = w_operand;
                  OP_OUT: if (w_out_stall) begin
                     w_pc_next    = r_pc;
                     w_state_next = ST_STALL_OUT;
                  end
                  OP_HALT: begin
                     w_pc_next    = r_pc;
                     w_state_next = ST_HALTED;
                  end
                  default: ;
               endcase
            end
         end
         ST_STALL_OUT: if (w_accept) w_state_next = ST_EXEC;
         ST_HALTED:    ;
         default:      w_state_next = ST_EXEC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EXEC;
         r_pc        <= '0;
         r_r0        <= '0;
         r_r1        <= '0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (w_out_load) begin
            r_out_data  <= r_r0;
            r_out_valid <= 1'b1;
         end else if (w_accept) begin
            r_out_valid <= 1'b0;
         end
         if (w_exec) begin
            if (w_flag_op) begin
               r_r0 <= w_alu_result;
               r_c  <= w_alu_c;
               r_z  <= w_alu_z;
            end
            case (w_opcode)
               OP_LDI: r_r0 <= w_imm;
               OP_LDA: r_r0 <= r_ram[w_operand];
               OP_STA: r_ram[w_operand] <= r_r0;
               OP_MOV: r_r1 <= r_r0;
               OP_LDB: r_r1 <= r_ram[w_operand];
               OP_SWP: begin
                  r_r0 <= r_r1;
                  r_r1 <= r_r0;
               end
               default: ;
            endcase
         end
      end
   end

   assign imem_addr           = r_pc;
   assign pc_debug            = r_pc;
   assign instr_debug         = imem_data;
   assign out_data            = r_out_data;
   assign out_valid           = r_out_valid;
   assign halted              = (r_state == ST_HALTED);
   assign dbg_ram_data        = r_ram[dbg_ram_addr];
   assign r0_debug            = r_r0;
   assign r1_debug            = r_r1;
   assign flags_debug[FLAG_C] = r_c;
   assign flags_debug[FLAG_Z] = r_z;

endmodule

// File: tb/tb_cpu_core_param.sv
// tb/tb_cpu_core_param.sv - self-checking bench: ALU vector table, OUT scoreboard, control corner cases
module tb_cpu_core_param;
   import cpu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1, run = 1'b0, step = 1'b0, out_ready = 1'b0;
   logic run_b = 1'b0, step_b = 1'b0;

   logic [3:0] imem_addr_a, out_data_a, dbg_addr_a, dbg_data_a, pc_a, r0_a, r1_a;
   logic [7:0] imem_data_a, instr_a;
   logic       out_valid_a, halted_a;
   logic [1:0] flags_a;
   logic [7:0] imem_a [16];

   logic [5:0] imem_addr_b, dbg_addr_b, pc_b;
   logic [9:0] imem_data_b, instr_b;
   logic [7:0] out_data_b, dbg_data_b, r0_b, r1_b;
   logic       out_valid_b, halted_b;
   logic [1:0] flags_b;
   logic [9:0] imem_b [64];

   assign imem_data_a = imem_a[imem_addr_a];
   assign imem_data_b = imem_b[imem_addr_b];

   cpu_core_param u_dut_a (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .imem_addr(imem_addr_a), .imem_data(imem_data_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
      .halted(halted_a), .dbg_ram_addr(dbg_addr_a), .dbg_ram_data(dbg_data_a),
      .pc_debug(pc_a), .instr_debug(instr_a), .r0_debug(r0_a), .r1_debug(r1_a),
      .flags_debug(flags_a)
   );

   cpu_core_param #(.DATA_W(8), .ADDR_W(6), .INSTR_W(10)) u_dut_b (
      .clk(clk), .reset(reset), .run(run_b), .step(step_b),
      .imem_addr(imem_addr_b), .imem_data(imem_data_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .halted(halted_b), .dbg_ram_addr(dbg_addr_b), .dbg_ram_data(dbg_data_b),
      .pc_debug(pc_b), .instr_debug(instr_b), .r0_debug(r0_b), .r1_debug(r1_b),
      .flags_debug(flags_b)
   );

   int n_checks = 0;
   int n_err    = 0;
   int n_xfers  = 0;
   logic [3:0] exp_q [$];

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] r0;
      logic [1:0] f;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] ia(input logic [3:0] op, input logic [3:0] opnd);
      return {op, opnd};
   endfunction

   function automatic logic [9:0] ib(input logic [3:0] op, input logic [5:0] opnd);
      return {op, opnd};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 16; i++) imem_a[i] = 8'h00;
      for (int i = 0; i < 64; i++) imem_b[i] = 10'h000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; run = 1'b0; run_b = 1'b0; step = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_halt(input string nm, input int max);
      int i = 0;
      while (!halted_a && i < max) begin
         @(negedge clk);
         i++;
      end
      check(nm, 32'(halted_a), 32'd1);
   endtask

   task automatic pulse_step();
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
   endtask

   // Scoreboard: every accepted transfer must match the next value queued by the stimulus.
   always @(posedge clk) begin
      if (!reset && out_valid_a && out_ready) begin
         n_xfers++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL out_xfer: got %0h expected no transfer", out_data_a);
         end else begin
            check("out_xfer", 32'(out_data_a), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] acc;

      vecs[0] = '{OP_ADD, 4'd3,  4'd4,  4'd7,  2'b00};
      vecs[1] = '{OP_ADD, 4'd9,  4'd8,  4'd1,  2'b10};
      vecs[2] = '{OP_ADD, 4'd8,  4'd8,  4'd0,  2'b11};
      vecs[3] = '{OP_SUB, 4'd5,  4'd3,  4'd2,  2'b00};
      vecs[4] = '{OP_SUB, 4'd3,  4'd5,  4'd14, 2'b10};
      vecs[5] = '{OP_SUB, 4'd6,  4'd6,  4'd0,  2'b01};
      vecs[6] = '{OP_AND, 4'd12, 4'd10, 4'd8,  2'b10};
      vecs[7] = '{OP_AND, 4'd12, 4'd3,  4'd0,  2'b11};
      vecs[8] = '{OP_XOR, 4'd5,  4'd5,  4'd0,  2'b11};
      vecs[9] = '{OP_XOR, 4'd9,  4'd6,  4'd15, 2'b10};
      dbg_addr_a = 4'd3;
      dbg_addr_b = 6'd63;

      // Legacy program and reset state
      clear_imem();
      imem_a[0] = ia(OP_LDI, 4'd2);
      imem_a[1] = ia(OP_MOV, 4'd0);
      imem_a[2] = ia(OP_LDI, 4'd3);
      imem_a[3] = ia(OP_ADD, 4'd0);
      imem_a[4] = ia(OP_STA, 4'd3);
      imem_a[5] = ia(OP_HALT, 4'd0);
      do_reset();
      check("rst_pc", 32'(pc_a), 32'd0);
      check("rst_r0", 32'(r0_a), 32'd0);
      check("rst_flags", 32'(flags_a), 32'd0);
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_halted", 32'(halted_a), 32'd0);
      run = 1'b1; out_ready = 1'b1;
      repeat (7) @(negedge clk);
      check("legacy_halted", 32'(halted_a), 32'd1);
      check("legacy_ram3", 32'(dbg_data_a), 32'd5);
      check("legacy_r0", 32'(r0_a), 32'd5);
      check("legacy_r1", 32'(r1_a), 32'd2);
      check("legacy_flags", 32'(flags_a), 32'd0);
      check("legacy_pc", 32'(pc_a), 32'd5);
      check("legacy_instr", 32'(instr_a), 32'(ia(OP_HALT, 4'd0)));
      repeat (3) @(negedge clk);
      check("legacy_pc_hold", 32'(pc_a), 32'd5);

      // ALU table: preset C=1,Z=1, then op under test, result sent through OUT
      foreach (vecs[k]) begin
         clear_imem();
         imem_a[0] = ia(OP_LDI, 4'd15);
         imem_a[1] = ia(OP_MOV, 4'd0);
         imem_a[2] = ia(OP_LDI, 4'd1);
         imem_a[3] = ia(OP_ADD, 4'd0);
         imem_a[4] = ia(OP_LDI, vecs[k].b);
         imem_a[5] = ia(OP_MOV, 4'd0);
         imem_a[6] = ia(OP_LDI, vecs[k].a);
         imem_a[7] = ia(vecs[k].op, 4'd0);
         imem_a[8] = ia(OP_OUT, 4'd0);
         imem_a[9] = ia(OP_HALT, 4'd0);
         do_reset();
         exp_q.push_back(vecs[k].r0);
         out_ready = 1'b1; run = 1'b1;
         wait_halt("vec_halt", 30);
         check($sformatf("vec%0d_r0", k), 32'(r0_a), 32'(vecs[k].r0));
         check($sformatf("vec%0d_r1", k), 32'(r1_a), 32'(vecs[k].b));
         check($sformatf("vec%0d_flags", k), 32'(flags_a), 32'(vecs[k].f));
      end

      // Wrap and carry branch
      clear_imem();
      imem_a[0] = ia(OP_LDI, 4'd15);
      imem_a[1] = ia(OP_MOV, 4'd0);
      imem_a[2] = ia(OP_LDI, 4'd1);
      imem_a[3] = ia(OP_ADD, 4'd0);
      imem_a[4] = ia(OP_JC, 4'd7);
      imem_a[5] = ia(OP_LDI, 4'd3);
      imem_a[6] = ia(OP_LDI, 4'd3);
      imem_a[7] = ia(OP_HALT, 4'd0);
      do_reset();
      run = 1'b1;
      wait_halt("jc_halt", 30);
      check("jc_pc", 32'(pc_a), 32'd7);
      check("jc_r0", 32'(r0_a), 32'd0);
      check("jc_flags", 32'(flags_a), 32'd3);

      // PC wrap from 15 to 0 using single steps
      clear_imem();
      imem_a[0] = ia(OP_JMP, 4'd15);
      do_reset();
      pulse_step();
      check("wrap_pc15", 32'(pc_a), 32'd15);
      pulse_step();
      check("wrap_pc0", 32'(pc_a), 32'd0);

      // Step mode
      clear_imem();
      imem_a[0] = ia(OP_LDI, 4'd2);
      imem_a[1] = ia(OP_MOV, 4'd0);
      imem_a[2] = ia(OP_LDI, 4'd7);
      imem_a[3] = ia(OP_ADD, 4'd0);
      imem_a[4] = ia(OP_SUB, 4'd0);
      imem_a[5] = ia(OP_HALT, 4'd0);
      do_reset();
      repeat (3) @(negedge clk);
      check("step_idle_pc", 32'(pc_a), 32'd0);
      pulse_step();
      repeat (3) @(negedge clk);
      check("step1_pc", 32'(pc_a), 32'd1);
      check("step1_r0", 32'(r0_a), 32'd2);
      pulse_step();
      repeat (2) @(negedge clk);
      check("step2_pc", 32'(pc_a), 32'd2);
      check("step2_r1", 32'(r1_a), 32'd2);
      @(negedge clk); step = 1'b1;
      repeat (3) @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      check("step_held_pc", 32'(pc_a), 32'd5);
      check("step_held_r0", 32'(r0_a), 32'd7);

      // OUT backpressure with two transfers
      clear_imem();
      imem_a[0] = ia(OP_LDI, 4'd9);
      imem_a[1] = ia(OP_OUT, 4'd0);
      imem_a[2] = ia(OP_LDI, 4'd4);
      imem_a[3] = ia(OP_OUT, 4'd0);
      imem_a[4] = ia(OP_HALT, 4'd0);
      out_ready = 1'b0;
      do_reset();
      n_xfers = 0;
      exp_q.push_back(4'd9);
      exp_q.push_back(4'd4);
      run = 1'b1;
      repeat (5) @(negedge clk);
      check("bp_stall_pc", 32'(pc_a), 32'd3);
      check("bp_valid_held", 32'(out_valid_a), 32'd1);
      check("bp_data_held", 32'(out_data_a), 32'd9);
      check("bp_r0_progress", 32'(r0_a), 32'd4);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("bp_second_pc", 32'(pc_a), 32'd4);
      check("bp_second_data", 32'(out_data_a), 32'd4);
      wait_halt("bp_halt", 20);
      check("bp_valid_clear", 32'(out_valid_a), 32'd0);
      check("bp_xfer_count", 32'(n_xfers), 32'd2);

      // Reset while stalled on OUT
      clear_imem();
      imem_a[0] = ia(OP_LDI, 4'd9);
      imem_a[1] = ia(OP_STA, 4'd2);
      imem_a[2] = ia(OP_OUT, 4'd0);
      imem_a[3] = ia(OP_OUT, 4'd0);
      imem_a[4] = ia(OP_HALT, 4'd0);
      out_ready = 1'b0;
      do_reset();
      dbg_addr_a = 4'd2;
      run = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_stall_pc", 32'(pc_a), 32'd3);
      check("mid_ram2", 32'(dbg_data_a), 32'd9);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_pc", 32'(pc_a), 32'd0);
      check("mid_rst_r0", 32'(r0_a), 32'd0);
      check("mid_rst_r1", 32'(r1_a), 32'd0);
      check("mid_rst_valid", 32'(out_valid_a), 32'd0);
      check("mid_rst_halted", 32'(halted_a), 32'd0);
      acc = 4'd0;
      for (int i = 0; i < 16; i++) begin
         dbg_addr_a = 4'(i);
         #1;
         acc = acc | dbg_data_a;
      end
      check("mid_rst_ram_zero", 32'(acc), 32'd0);
      run = 1'b0;
      reset = 1'b0;

      // Generic widths DATA_W=8, ADDR_W=6
      clear_imem();
      imem_b[0] = ib(OP_LDI, 6'd40);
      imem_b[1] = ib(OP_MOV, 6'd0);
      imem_b[2] = ib(OP_LDI, 6'd50);
      imem_b[3] = ib(OP_ADD, 6'd0);
      imem_b[4] = ib(OP_STA, 6'd63);
      imem_b[5] = ib(OP_HALT, 6'd0);
      do_reset();
      run_b = 1'b1;
      for (int i = 0; i < 30 && !halted_b; i++) @(negedge clk);
      check("wide_halted", 32'(halted_b), 32'd1);
      check("wide_ram63", 32'(dbg_data_b), 32'd90);
      check("wide_r0", 32'(r0_b), 32'd90);
      check("wide_r1", 32'(r1_b), 32'd40);
      check("wide_flags", 32'(flags_b), 32'd0);
      check("wide_pc", 32'(pc_b), 32'd5);
      check("wide_instr", 32'(instr_b), 32'(ib(OP_HALT, 6'd0)));
      check("wide_no_out", 32'({out_valid_b, out_data_b}), 32'd0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
